// File: rtl/lsu_bus_ctrl_mb.sv
// Queued uncached/IO bus controller between the LSQ and a Wishbone classic port.
// Requests wait in a small in-order FIFO; the head request is split into one or
// more bus beats, its result is extended and presented to the writeback arbiter.
module lsu_bus_ctrl_mb #(
  parameter int XLEN               = 64,
  parameter int WB_DATA_LEN        = 32,
  parameter int PHYSICAL_ADDR_LEN  = 56,
  parameter int ROB_INDEX_WIDTH    = 6,
  parameter int PHY_REG_ADDR_WIDTH = 6,
  parameter int REQ_FIFO_DEPTH     = 2,
  parameter int TIMEOUT_W          = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  output logic                          bus_ctrl_lsq_rdy_o,
  input  logic                          lsq_bus_ctrl_req_vld_i,
  input  logic                          lsq_bus_ctrl_req_load_or_store_i,
  input  logic                          lsq_bus_ctrl_req_is_fence_i,
  input  logic [1:0]                    lsq_bus_ctrl_req_size_i,
  input  logic                          lsq_bus_ctrl_req_unsigned_i,
  input  logic [ROB_INDEX_WIDTH-1:0]    lsq_bus_ctrl_req_rob_index_i,
  input  logic [PHY_REG_ADDR_WIDTH-1:0] lsq_bus_ctrl_req_rd_addr_i,
  input  logic                          lsq_bus_ctrl_req_is_float_i,
  input  logic [PHYSICAL_ADDR_LEN-1:0]  lsq_bus_ctrl_req_paddr_i,
  input  logic [XLEN-1:0]               lsq_bus_ctrl_req_data_i,
  output logic                          bus_ctrl_wb_cyc_o,
  output logic                          bus_ctrl_wb_stb_o,
  output logic                          bus_ctrl_wb_we_o,
  output logic [PHYSICAL_ADDR_LEN-1:0]  bus_ctrl_wb_adr_o,
  output logic [WB_DATA_LEN-1:0]        bus_ctrl_wb_dat_o,
  output logic [WB_DATA_LEN/8-1:0]      bus_ctrl_wb_sel_o,
  input  logic                          wb_bus_ctrl_ack_i,
  input  logic                          wb_bus_ctrl_err_i,
  input  logic [WB_DATA_LEN-1:0]        wb_bus_ctrl_dat_i,
  output logic                          bus_ctrl_wb_arb_wb_vld_o,
  output logic [ROB_INDEX_WIDTH-1:0]    bus_ctrl_wb_arb_wb_rob_index_o,
  output logic                          bus_ctrl_wb_arb_exc_vld_o,
  output logic                          bus_ctrl_wb_arb_prf_wb_vld_o,
  output logic [PHY_REG_ADDR_WIDTH-1:0] bus_ctrl_wb_arb_prf_wb_rd_addr_o,
  output logic                          bus_ctrl_wb_arb_prf_wb_is_float_o,
  output logic [XLEN-1:0]               bus_ctrl_wb_arb_prf_wb_data_o,
  input  logic                          wb_arb_bus_ctrl_rdy_i
);

  localparam int BYTES  = WB_DATA_LEN / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int MAX_NB = XLEN / WB_DATA_LEN;
  localparam int K_W    = (MAX_NB > 1) ? $clog2(MAX_NB) : 1;
  localparam int PTR_W  = $clog2(REQ_FIFO_DEPTH);
  localparam int TO_W   = (TIMEOUT_W > 0) ? TIMEOUT_W : 1;
  localparam bit TO_EN  = (TIMEOUT_W > 0);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BUS   = 3'd1;
  localparam logic [2:0] S_GAP   = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  typedef struct packed {
    logic                          store;
    logic                          fence;
    logic [1:0]                    size;
    logic                          uns;
    logic [ROB_INDEX_WIDTH-1:0]    rob;
    logic [PHY_REG_ADDR_WIDTH-1:0] rd;
    logic                          fp;
    logic [PHYSICAL_ADDR_LEN-1:0]  paddr;
    logic [XLEN-1:0]               data;
  } req_t;

  // Zero- or sign-extends the low 2^sz bytes of v.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] v,
                                               input logic [1:0] sz, input logic uns);
    logic [XLEN-1:0] mask;
    logic [6:0]      nbits;
    logic            sign;
    nbits    = 7'd8 << sz;
    mask     = (sz == 2'd3) ? '1 : ((XLEN'(1) << nbits) - XLEN'(1));
    sign     = |(v & (XLEN'(1) << (nbits - 7'd1)));
    load_ext = v & mask;
    if (!uns && (sz != 2'd3) && sign) load_ext = load_ext | ~mask;
  endfunction

  req_t                 fifo_mem [REQ_FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]       count_q;
  logic                 full, empty, enq, deq;
  req_t                 req_in, head;

  logic [2:0]                   state_q, state_d;
  logic [K_W-1:0]               k_q, k_d, beat_k, nb_m1;
  logic [TO_W-1:0]              to_q, to_d;
  logic                         cyc_q, cyc_d, we_q, we_d;
  logic [PHYSICAL_ADDR_LEN-1:0] adr_q, adr_d, beat_adr;
  logic [WB_DATA_LEN-1:0]       dat_q, dat_d, beat_dat;
  logic [BYTES-1:0]             sel_q, sel_d, beat_sel;
  logic [XLEN-1:0]              rbuf_q, rbuf_d;
  logic                         wbv_q, wbv_d, exc_q, exc_d, prfv_q, prfv_d, fp_q, fp_d;
  logic [ROB_INDEX_WIDTH-1:0]   rob_q, rob_d;
  logic [PHY_REG_ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [XLEN-1:0]              wdata_q, wdata_d;

  logic [OFF_W-1:0]   head_off;
  logic [3:0]         acc_bytes;
  logic               multi;
  logic [2*BYTES-1:0] sel_wide;
  logic               timeout_hit, bus_done, start_beat, enter_wb;

  assign req_in = '{store: lsq_bus_ctrl_req_load_or_store_i, fence: lsq_bus_ctrl_req_is_fence_i,
                    size: lsq_bus_ctrl_req_size_i, uns: lsq_bus_ctrl_req_unsigned_i,
                    rob: lsq_bus_ctrl_req_rob_index_i, rd: lsq_bus_ctrl_req_rd_addr_i,
                    fp: lsq_bus_ctrl_req_is_float_i, paddr: lsq_bus_ctrl_req_paddr_i,
                    data: lsq_bus_ctrl_req_data_i};

  assign head  = fifo_mem[rd_ptr_q];
  assign full  = (count_q == (PTR_W+1)'(REQ_FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign deq   = (state_q == S_WB) & wb_arb_bus_ctrl_rdy_i & ~flush;
  // A full FIFO still accepts when the head retires in the same cycle.
  assign bus_ctrl_lsq_rdy_o = (~full | deq) & ~flush & (state_q != S_DRAIN);
  assign enq   = lsq_bus_ctrl_req_vld_i & bus_ctrl_lsq_rdy_o;

  // Beat geometry of the head request.
  assign head_off  = head.paddr[OFF_W-1:0];
  assign acc_bytes = 4'd1 << head.size;
  assign multi     = (acc_bytes > 4'(BYTES));
  assign nb_m1     = multi ? K_W'((acc_bytes >> OFF_W) - 4'd1) : '0;
  assign beat_k    = (state_q == S_GAP) ? k_q + K_W'(1) : '0;
  assign sel_wide  = (((2*BYTES)'(1) << acc_bytes) - (2*BYTES)'(1)) << head_off;
  assign beat_sel  = multi ? '1 : sel_wide[BYTES-1:0];
  assign beat_dat  = multi ? head.data[beat_k*WB_DATA_LEN +: WB_DATA_LEN]
                           : (head.data[WB_DATA_LEN-1:0] << {head_off, 3'b000});
  assign beat_adr  = {head.paddr[PHYSICAL_ADDR_LEN-1:OFF_W], {OFF_W{1'b0}}}
                   + (PHYSICAL_ADDR_LEN'(beat_k) << OFF_W);

  assign timeout_hit = TO_EN && (to_q == '1);
  assign bus_done    = wb_bus_ctrl_ack_i | wb_bus_ctrl_err_i | timeout_hit;

  // Request storage write port.
  // NOTE: FIFO payload is not reset; count/pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (enq) fifo_mem[wr_ptr_q] <= req_in;
  end

  // FIFO pointers and occupancy; flush empties the queue at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (enq && !deq)      count_q <= count_q + (PTR_W+1)'(1);
      else if (deq && !enq) count_q <= count_q - (PTR_W+1)'(1);
    end
  end

  // Next-state logic for the FSM, bus signals and completion fields.
  // NOTE: every signal gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q; k_d = k_q; to_d = to_q;
    cyc_d = cyc_q; we_d = we_q; adr_d = adr_q; dat_d = dat_q; sel_d = sel_q;
    rbuf_d = rbuf_q;
    wbv_d = wbv_q; exc_d = exc_q; prfv_d = prfv_q; wdata_d = wdata_q;
    rob_d = rob_q; rd_d = rd_q; fp_d = fp_q;
    start_beat = 1'b0; enter_wb = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!flush && !empty) begin
          if (head.fence) begin
            enter_wb = 1'b1; exc_d = 1'b0; prfv_d = 1'b0; wdata_d = '0;
          end else begin
            start_beat = 1'b1;
          end
        end
      end
      S_BUS: begin
        if (flush) begin
          state_d = bus_done ? S_IDLE : S_DRAIN;
          if (bus_done) cyc_d = 1'b0;
          else          to_d  = to_q + TO_W'(1);
        end else if (wb_bus_ctrl_err_i || (timeout_hit && !wb_bus_ctrl_ack_i)) begin
          cyc_d = 1'b0; enter_wb = 1'b1;
          exc_d = 1'b1; prfv_d = 1'b0; wdata_d = '0;
        end else if (wb_bus_ctrl_ack_i) begin
          cyc_d = 1'b0;
          if (multi) rbuf_d[k_q*WB_DATA_LEN +: WB_DATA_LEN] = wb_bus_ctrl_dat_i;
          else       rbuf_d = XLEN'(wb_bus_ctrl_dat_i >> {head_off, 3'b000});
          if (k_q != nb_m1) begin
            state_d = S_GAP;
          end else begin
            enter_wb = 1'b1; exc_d = 1'b0; prfv_d = ~head.store;
            wdata_d  = head.store ? '0 : load_ext(rbuf_d, head.size, head.uns);
          end
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_GAP: begin
        if (flush) state_d = S_IDLE;
        else       start_beat = 1'b1;
      end
      S_WB: begin
        if (flush || wb_arb_bus_ctrl_rdy_i) begin
          state_d = S_IDLE;
          wbv_d = 1'b0; exc_d = 1'b0; prfv_d = 1'b0;
        end
      end
      S_DRAIN: begin
        if (bus_done) begin
          state_d = S_IDLE; cyc_d = 1'b0;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (start_beat) begin
      state_d = S_BUS; k_d = beat_k; to_d = '0;
      cyc_d = 1'b1; we_d = head.store; adr_d = beat_adr; dat_d = beat_dat; sel_d = beat_sel;
    end
    if (enter_wb) begin
      state_d = S_WB; wbv_d = 1'b1;
      rob_d = head.rob; rd_d = head.rd; fp_d = head.fp;
    end
  end

  // State and output registers.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE; k_q <= '0; to_q <= '0;
      cyc_q <= 1'b0; we_q <= 1'b0; adr_q <= '0; dat_q <= '0; sel_q <= '0;
      rbuf_q <= '0;
      wbv_q <= 1'b0; exc_q <= 1'b0; prfv_q <= 1'b0; wdata_q <= '0;
      rob_q <= '0; rd_q <= '0; fp_q <= 1'b0;
    end else begin
      state_q <= state_d; k_q <= k_d; to_q <= to_d;
      cyc_q <= cyc_d; we_q <= we_d; adr_q <= adr_d; dat_q <= dat_d; sel_q <= sel_d;
      rbuf_q <= rbuf_d;
      wbv_q <= wbv_d; exc_q <= exc_d; prfv_q <= prfv_d; wdata_q <= wdata_d;
      rob_q <= rob_d; rd_q <= rd_d; fp_q <= fp_d;
    end
  end

  assign bus_ctrl_wb_cyc_o = cyc_q;
  assign bus_ctrl_wb_stb_o = cyc_q;
  assign bus_ctrl_wb_we_o  = we_q;
  assign bus_ctrl_wb_adr_o = adr_q;
  assign bus_ctrl_wb_dat_o = dat_q;
  assign bus_ctrl_wb_sel_o = sel_q;

  assign bus_ctrl_wb_arb_wb_vld_o          = wbv_q;
  assign bus_ctrl_wb_arb_wb_rob_index_o    = rob_q;
  assign bus_ctrl_wb_arb_exc_vld_o         = exc_q;
  assign bus_ctrl_wb_arb_prf_wb_vld_o      = prfv_q;
  assign bus_ctrl_wb_arb_prf_wb_rd_addr_o  = rd_q;
  assign bus_ctrl_wb_arb_prf_wb_is_float_o = fp_q;
  assign bus_ctrl_wb_arb_prf_wb_data_o     = wdata_q;

endmodule

// File: tb/tb_lsu_bus_ctrl_mb.sv
// Directed bench for lsu_bus_ctrl_mb with default parameters (32-bit bus, depth 2).
module tb_lsu_bus_ctrl_mb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        rdy_o;
  logic        vld = 1'b0, st = 1'b0, fence = 1'b0, uns = 1'b0, fp = 1'b0;
  logic [1:0]  sz = '0;
  logic [5:0]  rob = '0, rd = '0;
  logic [55:0] pa = '0;
  logic [63:0] sdata = '0;
  logic        cyc, stb, we;
  logic [55:0] adr;
  logic [31:0] dat_o;
  logic [3:0]  sel;
  logic        ack = 1'b0, err = 1'b0;
  logic [31:0] dat_i = '0;
  logic        wb_vld, exc, prf_vld, prf_fp;
  logic [5:0]  wb_rob, prf_rd;
  logic [63:0] prf_data;
  logic        arb_rdy = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lsu_bus_ctrl_mb dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .bus_ctrl_lsq_rdy_o(rdy_o),
    .lsq_bus_ctrl_req_vld_i(vld),
    .lsq_bus_ctrl_req_load_or_store_i(st),
    .lsq_bus_ctrl_req_is_fence_i(fence),
    .lsq_bus_ctrl_req_size_i(sz),
    .lsq_bus_ctrl_req_unsigned_i(uns),
    .lsq_bus_ctrl_req_rob_index_i(rob),
    .lsq_bus_ctrl_req_rd_addr_i(rd),
    .lsq_bus_ctrl_req_is_float_i(fp),
    .lsq_bus_ctrl_req_paddr_i(pa),
    .lsq_bus_ctrl_req_data_i(sdata),
    .bus_ctrl_wb_cyc_o(cyc), .bus_ctrl_wb_stb_o(stb), .bus_ctrl_wb_we_o(we),
    .bus_ctrl_wb_adr_o(adr), .bus_ctrl_wb_dat_o(dat_o), .bus_ctrl_wb_sel_o(sel),
    .wb_bus_ctrl_ack_i(ack), .wb_bus_ctrl_err_i(err), .wb_bus_ctrl_dat_i(dat_i),
    .bus_ctrl_wb_arb_wb_vld_o(wb_vld),
    .bus_ctrl_wb_arb_wb_rob_index_o(wb_rob),
    .bus_ctrl_wb_arb_exc_vld_o(exc),
    .bus_ctrl_wb_arb_prf_wb_vld_o(prf_vld),
    .bus_ctrl_wb_arb_prf_wb_rd_addr_o(prf_rd),
    .bus_ctrl_wb_arb_prf_wb_is_float_o(prf_fp),
    .bus_ctrl_wb_arb_prf_wb_data_o(prf_data),
    .wb_arb_bus_ctrl_rdy_i(arb_rdy)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Presents one request for a single accepted cycle (bounded wait on rdy_o).
  task automatic send(input logic i_st, input logic i_fence, input logic [1:0] i_sz,
                      input logic i_uns, input logic [5:0] i_rob, input logic [5:0] i_rd,
                      input logic [55:0] i_pa, input logic [63:0] i_d);
    int w = 0;
    while (!rdy_o && w < 50) begin tick(); w++; end
    n_cmp++;
    if (rdy_o !== 1'b1) begin n_err++; $display("FAIL send_rdy got %b need 1", rdy_o); end
    st = i_st; fence = i_fence; sz = i_sz; uns = i_uns; rob = i_rob; rd = i_rd;
    pa = i_pa; sdata = i_d; fp = 1'b0; vld = 1'b1;
    tick();
    vld = 1'b0;
  endtask

  task automatic wait_cyc(input string name);
    int w = 0;
    while (cyc !== 1'b1 && w < 50) begin tick(); w++; end
    n_cmp++;
    if (cyc !== 1'b1) begin n_err++; $display("FAIL %s_cyc got %b need 1", name, cyc); end
  endtask

  task automatic wait_wb(input string name);
    int w = 0;
    while (wb_vld !== 1'b1 && w < 50) begin tick(); w++; end
    n_cmp++;
    if (wb_vld !== 1'b1) begin n_err++; $display("FAIL %s_wbvld got %b need 1", name, wb_vld); end
  endtask

  task automatic ack_beat(input logic [31:0] d);
    ack = 1'b1; dat_i = d;
    tick();
    ack = 1'b0; dat_i = '0;
  endtask

  task automatic release_wb();
    arb_rdy = 1'b1;
    tick();
    arb_rdy = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (cyc !== 1'b0 || stb !== 1'b0) begin n_err++; $display("FAIL rst_cyc got %b need 0", cyc); end
    n_cmp++; if (wb_vld !== 1'b0) begin n_err++; $display("FAIL rst_wbvld got %b need 0", wb_vld); end
    n_cmp++; if (prf_data !== 64'h0) begin n_err++; $display("FAIL rst_data got %h need 0", prf_data); end
    #20 rst_n = 1'b1;
    tick();
    n_cmp++; if (rdy_o !== 1'b1) begin n_err++; $display("FAIL rst_rdy got %b need 1", rdy_o); end
  endtask

  task automatic test_two_beat_load();
    send(1'b0, 1'b0, 2'd3, 1'b0, 6'd5, 6'd9, 56'h8000_1000, 64'h0);
    wait_cyc("t1a");
    n_cmp++; if (adr !== 56'h8000_1000) begin n_err++; $display("FAIL t1_adr0 got %h need 80001000", adr); end
    n_cmp++; if (sel !== 4'hF || we !== 1'b0) begin n_err++; $display("FAIL t1_sel0 got %h/%b need f/0", sel, we); end
    ack_beat(32'h1122_3344);
    n_cmp++; if (cyc !== 1'b0) begin n_err++; $display("FAIL t1_gap got %b need 0", cyc); end
    tick();
    n_cmp++; if (cyc !== 1'b1 || adr !== 56'h8000_1004) begin n_err++; $display("FAIL t1_beat1 got %b/%h need 1/80001004", cyc, adr); end
    ack_beat(32'h5566_7788);
    wait_wb("t1");
    n_cmp++; if (prf_data !== 64'h5566_7788_1122_3344) begin n_err++; $display("FAIL t1_data got %h need 5566778811223344", prf_data); end
    n_cmp++; if (prf_vld !== 1'b1 || exc !== 1'b0) begin n_err++; $display("FAIL t1_prf got %b/%b need 1/0", prf_vld, exc); end
    n_cmp++; if (wb_rob !== 6'd5 || prf_rd !== 6'd9) begin n_err++; $display("FAIL t1_tags got %0d/%0d need 5/9", wb_rob, prf_rd); end
    release_wb();
    n_cmp++; if (wb_vld !== 1'b0) begin n_err++; $display("FAIL t1_retire got %b need 0", wb_vld); end
  endtask

  task automatic test_byte_load();
    send(1'b0, 1'b0, 2'd0, 1'b0, 6'd6, 6'd10, 56'h8000_1003, 64'h0);
    wait_cyc("t2lb");
    n_cmp++; if (sel !== 4'b1000 || adr !== 56'h8000_1000) begin n_err++; $display("FAIL t2_sel got %b/%h need 1000/80001000", sel, adr); end
    ack_beat(32'h8000_0000);
    wait_wb("t2lb");
    n_cmp++; if (prf_data !== 64'hFFFF_FFFF_FFFF_FF80) begin n_err++; $display("FAIL t2_lb got %h need ffffffffffffff80", prf_data); end
    release_wb();
    send(1'b0, 1'b0, 2'd0, 1'b1, 6'd7, 6'd11, 56'h8000_1003, 64'h0);
    wait_cyc("t2lbu");
    ack_beat(32'h8000_0000);
    wait_wb("t2lbu");
    n_cmp++; if (prf_data !== 64'h80) begin n_err++; $display("FAIL t2_lbu got %h need 80", prf_data); end
    release_wb();
  endtask

  task automatic test_half_store();
    send(1'b1, 1'b0, 2'd1, 1'b0, 6'd8, 6'd0, 56'h8000_1002, 64'hBEEF);
    wait_cyc("t3");
    n_cmp++; if (sel !== 4'b1100 || we !== 1'b1) begin n_err++; $display("FAIL t3_sel got %b/%b need 1100/1", sel, we); end
    n_cmp++; if (dat_o !== 32'hBEEF_0000) begin n_err++; $display("FAIL t3_dat got %h need beef0000", dat_o); end
    ack_beat(32'h0);
    wait_wb("t3");
    n_cmp++; if (prf_vld !== 1'b0 || wb_rob !== 6'd8) begin n_err++; $display("FAIL t3_cmpl got %b/%0d need 0/8", prf_vld, wb_rob); end
    release_wb();
  endtask

  task automatic test_timeout();
    int cnt = 0;
    send(1'b0, 1'b0, 2'd2, 1'b0, 6'd30, 6'd1, 56'h8000_1010, 64'h0);
    wait_cyc("t4");
    while (cyc === 1'b1 && cnt < 400) begin tick(); cnt++; end
    n_cmp++; if (cnt < 255 || cnt > 257) begin n_err++; $display("FAIL t4_len got %0d need 255..257", cnt); end
    wait_wb("t4");
    n_cmp++; if (exc !== 1'b1 || prf_vld !== 1'b0) begin n_err++; $display("FAIL t4_exc got %b/%b need 1/0", exc, prf_vld); end
    n_cmp++; if (wb_rob !== 6'd30) begin n_err++; $display("FAIL t4_rob got %0d need 30", wb_rob); end
    release_wb();
  endtask

  task automatic test_back_to_back();
    send(1'b0, 1'b1, 2'd0, 1'b0, 6'd10, 6'd0, 56'h0, 64'h0);
    send(1'b1, 1'b0, 2'd2, 1'b0, 6'd11, 6'd0, 56'h8000_1020, 64'h1234);
    n_cmp++; if (rdy_o !== 1'b0) begin n_err++; $display("FAIL t5_full got %b need 0", rdy_o); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (wb_vld !== 1'b1 || wb_rob !== 6'd10 || prf_vld !== 1'b0 || exc !== 1'b0) begin
        n_err++; $display("FAIL t5_fence_hold%0d got %b/%0d need 1/10", i, wb_vld, wb_rob);
      end
      tick();
    end
    st = 1'b0; fence = 1'b0; sz = 2'd2; uns = 1'b0; rob = 6'd12; rd = 6'd3;
    pa = 56'h8000_1024; sdata = '0; vld = 1'b1; arb_rdy = 1'b1;
    #1;
    n_cmp++; if (rdy_o !== 1'b1) begin n_err++; $display("FAIL t5_full_deq got %b need 1", rdy_o); end
    @(posedge clk); #1;
    vld = 1'b0; arb_rdy = 1'b0;
    wait_cyc("t5b");
    n_cmp++; if (adr !== 56'h8000_1020 || we !== 1'b1 || dat_o !== 32'h1234) begin n_err++; $display("FAIL t5_b got %h/%b/%h need 80001020/1/1234", adr, we, dat_o); end
    ack_beat(32'h0);
    wait_wb("t5b");
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (wb_vld !== 1'b1 || wb_rob !== 6'd11 || prf_vld !== 1'b0) begin
        n_err++; $display("FAIL t5_st_hold%0d got %b/%0d need 1/11", i, wb_vld, wb_rob);
      end
      tick();
    end
    release_wb();
    wait_cyc("t5c");
    n_cmp++; if (adr !== 56'h8000_1024) begin n_err++; $display("FAIL t5_c_adr got %h need 80001024", adr); end
    ack_beat(32'h8765_4321);
    wait_wb("t5c");
    n_cmp++; if (wb_rob !== 6'd12 || prf_rd !== 6'd3 || prf_vld !== 1'b1) begin n_err++; $display("FAIL t5_c_tags got %0d/%0d/%b need 12/3/1", wb_rob, prf_rd, prf_vld); end
    n_cmp++; if (prf_data !== 64'hFFFF_FFFF_8765_4321) begin n_err++; $display("FAIL t5_c_data got %h need ffffffff87654321", prf_data); end
    release_wb();
  endtask

  task automatic test_flush_drain();
    logic bad = 1'b0;
    send(1'b0, 1'b0, 2'd3, 1'b0, 6'd20, 6'd4, 56'h8000_2000, 64'h0);
    wait_cyc("t6");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (cyc !== 1'b1 || rdy_o !== 1'b0) begin n_err++; $display("FAIL t6_drain got %b/%b need 1/0", cyc, rdy_o); end
    repeat (3) tick();
    n_cmp++; if (cyc !== 1'b1) begin n_err++; $display("FAIL t6_hold got %b need 1", cyc); end
    ack_beat(32'hDEAD_BEEF);
    for (int i = 0; i < 4; i++) begin
      if (cyc !== 1'b0 || wb_vld !== 1'b0) bad = 1'b1;
      tick();
    end
    n_cmp++; if (bad !== 1'b0) begin n_err++; $display("FAIL t6_quiet got %b need 0", bad); end
    n_cmp++; if (rdy_o !== 1'b1) begin n_err++; $display("FAIL t6_rdy got %b need 1", rdy_o); end
    send(1'b0, 1'b0, 2'd2, 1'b1, 6'd21, 6'd5, 56'h8000_2008, 64'h0);
    wait_cyc("t6n");
    n_cmp++; if (adr !== 56'h8000_2008 || sel !== 4'hF) begin n_err++; $display("FAIL t6_next_adr got %h/%h need 80002008/f", adr, sel); end
    ack_beat(32'hCAFE_F00D);
    wait_wb("t6n");
    n_cmp++; if (prf_data !== 64'h0000_0000_CAFE_F00D || wb_rob !== 6'd21) begin n_err++; $display("FAIL t6_next_data got %h/%0d need cafef00d/21", prf_data, wb_rob); end
    release_wb();
  endtask

  initial begin
    test_reset();
    test_two_beat_load();
    test_byte_load();
    test_half_store();
    test_timeout();
    test_back_to_back();
    test_flush_drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
